dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Memory-side responder for the pipeline's data-memory port. It is the other end of the load/store request stream: the CPU issues a request, and the block serves it after a configurable number of wait states. The block holds a word-organised, byte-addressed, little-endian RAM and handles byte, half-word and word access, sign or zero extension of loads, and error reporting. It replaces the zero-wait combinational data memory when the team moves to a stallable memory stage.

Parameters:
DEPTH, 1024, number of 32-bit words in the RAM (power of two)
LATENCY, 2, wait-state cycles between request acceptance and response (0 allowed)

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  reset, asynchronous, active-low
req_valid_i  input  1  request present
req_ready_o  output  1  responder can accept a request
req_write_i  input  1  1 = store, 0 = load
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_width_i  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal
req_sign_extend_i  input  1  load extension: 1 = sign, 0 = zero
resp_valid_o  output  1  response present
resp_ready_i  input  1  requester takes the response
resp_rdata_o  output  32  load result, right-aligned and extended; 0 for stores and errors
resp_err_o  output  1  misaligned, out-of-range or illegal-width access

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - state = IDLE, req_ready_o = 1, resp_valid_o = 0, resp_rdata_o = 0, resp_err_o = 0, wait counter = 0.
  - RAM contents are not reset.
  - Reset mid-operation aborts the in-flight request. A pending store is not written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o, all request fields are latched.
  - If LATENCY > 0, go to WAIT with counter = LATENCY-1. If LATENCY = 0, go to RESP.
- WAIT:
  - req_ready_o = 0.
  - The counter decrements each cycle. At counter == 0, the access executes and the state moves to RESP.
- Access execution (on the edge entering RESP):
  - Error check on the latched request. Error if width == 11, or half with addr[0] = 1, or word with addr[1:0] != 0, or addr[31:2] >= DEPTH.
  - On error: resp_err_o = 1, resp_rdata_o = 0, no RAM write.
  - Store: writes the byte lanes selected by width and addr[1:0]. Byte uses lane addr[1:0] with wdata[7:0]. Half uses lanes {addr[1],0}..+1 with wdata[15:0]. Word uses all lanes. resp_rdata_o = 0.
  - Load: extracts the same lanes, right-aligns them, and fills the upper bits with bit 7/15 if req_sign_extend_i = 1, else with 0. The word result is passed unchanged.
- RESP:
  - resp_valid_o = 1, req_ready_o = 0.
  - resp_rdata_o and resp_err_o hold stable until the handshake.
  - On resp_ready_i = 1, go to IDLE. resp_valid_o and resp_err_o clear, and resp_rdata_o keeps its last value.
- Throughput:
  - Acceptance-to-resp_valid latency is LATENCY+1 cycles.
  - No overlap: a new request is accepted at the earliest one cycle after the response handshake.
  - Peak throughput is one request per LATENCY+2 cycles.
- Backpressure: resp_ready_i = 0 holds RESP indefinitely. req_valid_i is ignored while req_ready_o = 0.
- Request fields are sampled only at acceptance; later changes on the req inputs have no effect.
- Addresses wrap nowhere: out-of-range accesses always produce an error.

Decomposition:
- Shared package dmem_pkg holds:
  - width encodings WIDTH_BYTE = 2'b00, WIDTH_HALF = 2'b01, WIDTH_WORD = 2'b10
  - FSM state enum (IDLE, WAIT, RESP)
  - these encodings are also used by the CPU control decoder
- One combinational sub-module, dmem_lane_align, covers:
  - store: byte-enable and shifted write-data generation from width and addr[1:0]
  - load: lane extraction and sign/zero extension
  - the misalignment check
- The top block holds the FSM, counter, latched request and RAM.

Test Plan:
- LATENCY=2: word store addr 0x10 data 0xDEADBEEF -> resp_valid_o 3 cycles after acceptance, err 0, rdata 0; then word load 0x10 -> rdata 0xDEADBEEF.
- After the above, byte load 0x13 sign=1 -> 0xFFFFFFDE; byte load 0x13 sign=0 -> 0x000000DE; half load 0x10 sign=1 -> 0xFFFFBEEF.
- Byte store 0x11 data 0x00000055 over 0xDEADBEEF, then word load 0x10 -> 0xDEAD55EF (other lanes untouched).
- Half load 0x11, word store 0x12, width 11, and word load addr 4*DEPTH -> each gives resp_err_o=1, rdata 0; RAM is unchanged on readback.
- Hold resp_ready_i=0 for 5 cycles -> resp_valid_o and data stay stable, req_ready_o stays 0, and a new req_valid_i is not accepted; release -> req_ready_o=1 the next cycle.
- Reset asserted while a store is in WAIT -> outputs return to reset values immediately; readback shows the old data. Also repeat the first scenario with LATENCY=0 -> response 1 cycle after acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// dmem_pkg: access-width encodings and responder FSM states shared with the CPU decoder.
// Revision: 1.0
package dmem_pkg;

  localparam logic [1:0] WIDTH_BYTE    = 2'b00;
  localparam logic [1:0] WIDTH_HALF    = 2'b01;
  localparam logic [1:0] WIDTH_WORD    = 2'b10;
  localparam logic [1:0] WIDTH_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// dmem_lane_align: byte-lane steering for stores, load extraction/extension, alignment check.
// Revision: 1.0
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = i_wdata;
    o_rdata      = i_rdata;
    o_misaligned = 1'b0;
    case (i_width)
      WIDTH_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        // Replicating the data into every lane lets the byte enables do the steering.
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sign & w_shifted[7]}}, w_shifted[7:0]};
      end
      WIDTH_HALF: begin
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
        o_misaligned = i_addr_lo[0];
      end
      WIDTH_WORD: begin
        o_be         = 4'b1111;
        o_misaligned = (i_addr_lo != 2'b00);
      end
      default: begin
        o_misaligned = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// dmem_responder: byte-addressed little-endian data RAM served after LATENCY wait states.
// Revision: 1.0
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_width_i,
  input  logic        req_sign_extend_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            r_state;
  logic [c_cw-1:0]   r_cnt;
  logic              r_write;
  logic              r_sign;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_width;
  logic [31:0]       r_mem [DEPTH];

  logic              w_idle;
  logic              w_exec;
  logic              w_write;
  logic              w_sign;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic [1:0]        w_width;
  logic [c_aw-1:0]   w_idx;
  logic              w_misaligned;
  logic              w_range_err;
  logic              w_err;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_sh;
  logic [31:0]       w_word;
  logic [31:0]       w_load;

  assign w_idle = (r_state == IDLE);

  // With zero wait states the access executes on the acceptance edge, before the latch holds it.
  assign w_write = w_idle ? req_write_i       : r_write;
  assign w_sign  = w_idle ? req_sign_extend_i : r_sign;
  assign w_addr  = w_idle ? req_addr_i        : r_addr;
  assign w_wdata = w_idle ? req_wdata_i       : r_wdata;
  assign w_width = w_idle ? req_width_i       : r_width;

  assign w_exec = (w_idle && req_valid_i && (LATENCY == 0)) ||
                  ((r_state == WAIT) && (r_cnt == '0));

  assign w_idx       = w_addr[c_aw+1:2];
  assign w_range_err = ({2'b00, w_addr[31:2]} >= 32'(DEPTH));
  assign w_err       = w_misaligned | w_range_err;
  assign w_word      = r_mem[w_idx];

  dmem_lane_align u_lane_align (
    .i_width      (w_width),
    .i_addr_lo    (w_addr[1:0]),
    .i_sign       (w_sign),
    .i_wdata      (w_wdata),
    .i_rdata      (w_word),
    .o_be         (w_be),
    .o_wdata      (w_wdata_sh),
    .o_rdata      (w_load),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i && w_exec && w_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_sign       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_width      <= WIDTH_BYTE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_write     <= req_write_i;
            r_sign      <= req_sign_extend_i;
            r_addr      <= req_addr_i;
            r_wdata     <= req_wdata_i;
            r_width     <= req_width_i;
            req_ready_o <= 1'b0;
            if (LATENCY == 0) begin
              r_state      <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= w_err;
              resp_rdata_o <= (w_err || w_write) ? 32'h0 : w_load;
            end else begin
              r_state <= WAIT;
              r_cnt   <= c_cw'((LATENCY > 0) ? LATENCY - 1 : 0);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state      <= RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= w_err;
            resp_rdata_o <= (w_err || w_write) ? 32'h0 : w_load;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            r_state      <= IDLE;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            req_ready_o  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// tb_dmem_responder: random and directed traffic against two responders (LATENCY 2 and 0).
// Revision: 1.0
module tb_dmem_responder;

  localparam int TB_DEPTH = 64;
  localparam int LAT0     = 2;
  localparam int LAT1     = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_width;
  logic        req_sign;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  logic [7:0]  mem [2][4*TB_DEPTH];
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  bit          bp_hold   = 1'b0;
  bit          force_rdy = 1'b0;
  int          n_checks  = 0;
  int          n_fail    = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(TB_DEPTH), .LATENCY(LAT0)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_width_i(req_width), .req_sign_extend_i(req_sign),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0])
  );

  dmem_responder #(.DEPTH(TB_DEPTH), .LATENCY(LAT1)) u_dut_l0 (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_width_i(req_width), .req_sign_extend_i(req_sign),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual timeout required response", name);
  endtask

  // Reference memory: byte array, accesses built from the width/alignment rules directly.
  task automatic model(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] wd, input bit sg, output logic [32:0] e);
    int n;
    logic [31:0] v;
    bit bad;
    n   = (wd == 2'd0) ? 1 : (wd == 2'd1) ? 2 : 4;
    bad = (wd == 2'd3) || ((a % n) != 0) || ((a >> 2) >= TB_DEPTH);
    if (bad) begin
      e = {1'b1, 32'h0};
    end else if (w) begin
      for (int i = 0; i < n; i++) mem[s][int'(a) + i] = d[8*i +: 8];
      e = 33'h0;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mem[s][int'(a) + i]) << (8*i));
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e = {1'b0, v};
    end
  endtask

  task automatic issue(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] wd, input bit sg);
    int k;
    logic [32:0] e;
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_width = wd; req_sign = sg;
    req_valid[s] = 1'b1;
    k = 0;
    while (!req_ready[s] && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready[s]) begin
      req_valid[s] = 1'b0;
      fail_now("accept_timeout");
      return;
    end
    model(s, w, a, d, wd, sg, e);
    if (s == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_width = 2'($urandom); req_sign = 1'($urandom);
    k = 1;
    while (!resp_valid[s] && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", 32'(k), 32'((s == 0) ? LAT0 + 1 : LAT1 + 1));
  endtask

  task automatic monitor(input int s);
    logic [32:0] e;
    bit r;
    forever begin
      @(negedge clk);
      r = bp_hold ? 1'b0 : (force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0));
      resp_ready[s] = r;
      if (resp_valid[s] && r) begin
        if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: actual response on dut %0d required none", s);
        end else begin
          e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk("resp_err", 32'(resp_err[s]), 32'(e[32]));
          chk("resp_rdata", resp_rdata[s], e[31:0]);
        end
      end
    end
  endtask

  task automatic wait_drain(input int s);
    int k;
    k = 0;
    while (((s == 0) ? exp_q0.size() : exp_q1.size()) != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain", 32'((s == 0) ? exp_q0.size() : exp_q1.size()), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_width = '0; req_sign = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s]  = 1'b0;
      resp_ready[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_req_ready", 32'(req_ready[s]), 32'h1);
      chk("rst_resp_valid", 32'(resp_valid[s]), 32'h0);
      chk("rst_resp_rdata", resp_rdata[s], 32'h0);
      chk("rst_resp_err", 32'(resp_err[s]), 32'h0);
    end
    rst_n = 1'b1;
    fork
      monitor(0);
      monitor(1);
    join_none

    for (int i = 0; i < TB_DEPTH; i++) begin
      issue(0, 1'b1, 32'(4*i), $urandom, 2'd2, 1'b0);
      issue(1, 1'b1, 32'(4*i), $urandom, 2'd2, 1'b0);
    end

    // Directed sequence on the LATENCY=2 responder.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
    issue(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    issue(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1);
    issue(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0);
    issue(0, 1'b0, 32'h10, 32'h0, 2'd1, 1'b1);
    issue(0, 1'b1, 32'h11, 32'h00000055, 2'd0, 1'b0);
    issue(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    issue(0, 1'b0, 32'h11, 32'h0, 2'd1, 1'b1);
    issue(0, 1'b1, 32'h12, 32'h11223344, 2'd2, 1'b0);
    issue(0, 1'b1, 32'h14, 32'h99887766, 2'd3, 1'b0);
    issue(0, 1'b0, 32'(4*TB_DEPTH), 32'h0, 2'd2, 1'b0);
    issue(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    issue(0, 1'b0, 32'h14, 32'h0, 2'd2, 1'b0);
    wait_drain(0);

    // Backpressure: response must hold while a competing request is offered.
    bp_hold = 1'b1;
    issue(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_write = 1'b1; req_addr = 32'h14; req_wdata = 32'hA5A5A5A5; req_width = 2'd2;
        req_valid[0] = 1'b1;
      end
      chk("bp_resp_valid", 32'(resp_valid[0]), 32'h1);
      chk("bp_resp_rdata", resp_rdata[0], 32'hDEAD55EF);
      chk("bp_resp_err", 32'(resp_err[0]), 32'h0);
      chk("bp_req_ready", 32'(req_ready[0]), 32'h0);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    force_rdy = 1'b1;
    bp_hold = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("bp_release_ready", 32'(req_ready[0]), 32'h1);
    chk("bp_release_valid", 32'(resp_valid[0]), 32'h0);
    force_rdy = 1'b0;
    wait_drain(0);
    issue(0, 1'b0, 32'h14, 32'h0, 2'd2, 1'b0);
    wait_drain(0);

    // Reset while a store sits in WAIT: nothing must be written.
    @(negedge clk);
    chk("pre_rst_ready", 32'(req_ready[0]), 32'h1);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_width = 2'd2;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready[0]), 32'h1);
    chk("mid_rst_resp_valid", 32'(resp_valid[0]), 32'h0);
    chk("mid_rst_resp_rdata", resp_rdata[0], 32'h0);
    chk("mid_rst_resp_err", 32'(resp_err[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);

    // Zero-latency responder, first scenario.
    issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
    issue(1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    issue(1, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1);

    for (int i = 0; i < 160; i++) begin
      issue(i % 2, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 4*TB_DEPTH + 7)),
            $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    wait_drain(0);
    wait_drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
